// File: rtl/rf_access_arbiter.sv
// Merges pipeline writeback and host register-file accesses onto one write port.
// Optional macro RF_HOST_READ_EN enables host reads through rf_raddr/rf_rdata.
module rf_access_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_wena,
    input  logic [4:0]  wb_waddr,
    input  logic [63:0] wb_wdata,
    input  logic        host_req,
    input  logic        host_we,
    input  logic [4:0]  host_addr,
    input  logic [63:0] host_wdata,
    input  logic [63:0] rf_rdata,
    output logic        rf_wena,
    output logic [4:0]  rf_waddr,
    output logic [63:0] rf_wdata,
    output logic [4:0]  rf_raddr,
    output logic        host_ack,
    output logic [63:0] host_rdata,
    output logic        pipe_stall
);

    typedef enum logic [1:0] {
        IDLE,
        PEND,
        ACK
    } state_t;

    state_t      state_q, state_d;
    logic        we_q, we_d;
    logic [4:0]  addr_q, addr_d;
    logic [63:0] wdata_q, wdata_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        stall_q, stall_d;
    logic [3:0]  cnt_inc;
    logic        stall_eff;
    logic        host_grant;

    // Reset forces the writeback path as if the pipeline were not stalled.
    assign stall_eff  = stall_q & ~rst;
    assign host_grant = (state_q == PEND) & we_q & ~rst
                      & (~wb_wena | stall_q);
    assign cnt_inc    = (cnt_q == 4'hF) ? cnt_q : cnt_q + 4'd1;

`ifdef RF_HOST_READ_EN
    logic [63:0] rdata_q, rdata_d;
    assign rf_raddr   = addr_q;
    assign host_rdata = rdata_q;
`else
    logic unused_rdata;
    assign unused_rdata = ^rf_rdata;
    assign rf_raddr     = 5'd0;
    assign host_rdata   = 64'd0;
`endif

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        stall_d = stall_q;
`ifdef RF_HOST_READ_EN
        rdata_d = rdata_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (host_req) begin
                    we_d    = host_we;
                    addr_d  = host_addr;
                    wdata_d = host_wdata;
                    cnt_d   = 4'd0;
                    state_d = PEND;
                end
            end
            PEND: begin
                if (!we_q) begin
`ifdef RF_HOST_READ_EN
                    rdata_d = rf_rdata;
`endif
                    state_d = ACK;
                end else if (host_grant) begin
                    state_d = ACK;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == 4'(STARVE_LIMIT)) begin
                        stall_d = 1'b1;
                    end
                end
            end
            ACK: begin
                stall_d = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            addr_q  <= 5'd0;
            wdata_q <= 64'd0;
            cnt_q   <= 4'd0;
            stall_q <= 1'b0;
`ifdef RF_HOST_READ_EN
            rdata_q <= 64'd0;
`endif
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
            stall_q <= stall_d;
`ifdef RF_HOST_READ_EN
            rdata_q <= rdata_d;
`endif
        end
    end

    always_comb begin
        if (host_grant) begin
            rf_wena  = (addr_q != 5'd0);
            rf_waddr = addr_q;
            rf_wdata = wdata_q;
        end else begin
            rf_wena  = wb_wena & ~stall_eff & (wb_waddr != 5'd0);
            rf_waddr = wb_waddr;
            rf_wdata = wb_wdata;
        end
    end

    assign host_ack   = (state_q == ACK) & ~rst;
    assign pipe_stall = stall_q;

endmodule

// File: doc/rf_access_arbiter.md
RF_ACCESS_ARBITER -- requirements
Module: rf_access_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 4: blocked host-write cycles before the pipeline is stalled; legal range 1..15.
REQ-002 clk  in  1  sole clock; all state updates on posedge clk.
REQ-003 rst  in  1  synchronous, active-high reset, sampled on posedge clk.
REQ-004 wb_wena / wb_waddr / wb_wdata  in  1/5/64  pipeline writeback request.
REQ-005 host_req / host_we / host_addr / host_wdata  in  1/1/5/64  host access request; fields held stable while host_req=1 until host_ack.
REQ-006 rf_rdata  in  64  register file software-read data for rf_raddr (combinational).
REQ-007 rf_wena / rf_waddr / rf_wdata  out  1/5/64  single merged register file write port.
REQ-008 rf_raddr  out  5  register file software-read address.
REQ-009 host_ack  out  1  one-cycle completion pulse.
REQ-010 host_rdata  out  64  read result, valid while host_ack=1.
REQ-011 pipe_stall  out  1  registered; while 1, the pipeline holds its writeback request unchanged.

Function
REQ-012 FSM states: IDLE, PEND, ACK.
- IDLE: host_req=1 -> latch we/addr/wdata, clear starve_cnt, go to PEND.
- ACK: host_ack=1, pipe_stall<=0, then IDLE.
REQ-013 PEND, host write: the host is granted when wb_wena=0 or pipe_stall=1. On grant, the FSM goes to ACK.
REQ-014 PEND, host write not granted: starve_cnt increments (4-bit, saturating). When the incremented value equals STARVE_LIMIT, pipe_stall<=1.
REQ-015 PEND, host read: rf_raddr=latched addr; host_rdata<=rf_rdata; go to ACK. Read needs no arbitration. A writeback landing in the same cycle is not reflected in the read data.
REQ-016 rf_wena/waddr/wdata are combinational:
- host granted in PEND: latched addr/wdata; rf_wena=1 unless addr=0.
- otherwise: wb fields; rf_wena = wb_wena & !pipe_stall & (wb_waddr != 0).
REQ-017 Register 0 is never written by either source. A host write to address 0 still completes with host_ack.
REQ-018 Latency: host write with wb idle -> rf_wena in the cycle after req is sampled, host_ack in the following cycle. Host read -> host_ack 2 cycles after req is sampled.
REQ-019 With wb_wena held at 1 continuously: pipe_stall rises after STARVE_LIMIT blocked PEND cycles, the host writes in the next cycle, and pipe_stall falls in the cycle after ACK.
REQ-020 Writeback is never dropped. It is only deferred while pipe_stall=1 and is performed once pipe_stall=0.
REQ-021 host_req is ignored outside IDLE. A req still high in IDLE after ACK starts a new transaction.
REQ-022 rf_raddr = latched addr in all states.
REQ-023 host_ack is never asserted for more than one consecutive cycle.

Reset
REQ-024 When rst=1: state=IDLE, starve_cnt=0, pipe_stall=0, host_ack=0, host_rdata=0, latched addr/wdata/we=0.
REQ-025 Reset in PEND or ACK aborts the transaction with no ack and no host write, and clears pipe_stall in the same edge.
REQ-026 rf_wena during rst=1 follows the wb path (REQ-016) with pipe_stall=0.

Configuration
REQ-027 Macro RF_HOST_READ_EN:
- defined: host reads behave per REQ-015.
- undefined: host reads complete via PEND->ACK with host_rdata=0, rf_raddr=0 constant, and no rf_rdata dependency.

Verification
REQ-028 wb idle; host write addr=7 data=0xDEAD_BEEF -> rf_wena=1, rf_waddr=7 one cycle after req is sampled; host_ack the next cycle.
REQ-029 wb_wena=1 held (addr 3, data 0x55); host write addr=9 data=0xAA; STARVE_LIMIT=4 -> pipe_stall=1 after 4 blocked cycles; next cycle rf_waddr=9; pipe_stall=0 after ack; wb write of 0x55 to r3 then occurs.
REQ-030 Host write addr=0 data=0xFFFF -> rf_wena stays 0; host_ack pulses once.
REQ-031 RF_HOST_READ_EN defined, rf_rdata model returns 0x1234 for addr 5; host read addr=5 -> host_ack with host_rdata=0x1234, 2 cycles after req. Undefined -> host_rdata=0.
REQ-032 Assert rst while in PEND with pipe_stall=1 -> next cycle state=IDLE, pipe_stall=0; no host_ack and no host write.
REQ-033 wb_wena=1, wb_waddr=0 with no host activity -> rf_wena=0.
